// File: rtl/usb_tx_encoder.sv
// rtl/usb_tx_encoder.sv - full-speed USB transmit bit engine (SYNC, bit stuffing, NRZI, EOP)
//
// Serializes payload bytes LSB-first onto D+/D-, one line bit every CLKS_PER_BIT clocks.
// Each packet is framed as SYNC (8'h80), payload bytes, then EOP (SE0, SE0, J).
//
// Ports
//   clk          in   system clock, rising edge
//   rst          in   synchronous active-high reset
//   tx_start     in   one-cycle packet request, ignored while tx_busy
//   tx_data      in   [7:0] next payload byte
//   tx_valid     in   tx_data/tx_last valid
//   tx_last      in   marks tx_data as the final payload byte
//   tx_ready     out  one-cycle byte-accept strobe (final cycle of bit 7)
//   d_plus_out   out  D+ line level (registered)
//   d_minus_out  out  D- line level (registered)
//   tx_busy      out  packet in progress
//   tx_done      out  pulse in the last cycle of a normally completed packet
//   tx_error     out  pulse when tx_valid is low during the tx_ready strobe
module usb_tx_encoder #(
    parameter int CLKS_PER_BIT = 8,
    parameter int STUFF_LEN    = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    input  logic       tx_last,
    output logic       tx_ready,
    output logic       d_plus_out,
    output logic       d_minus_out,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_error
);

    localparam int TW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int OW = $clog2(STUFF_LEN + 1);
    localparam logic [TW-1:0] T_LAST = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] T_PRE  = TW'(CLKS_PER_BIT - 2);
    localparam logic [OW-1:0] O_MAX  = OW'(STUFF_LEN);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SYNC,
        S_DATA,
        S_STUFF,
        S_EOP_SE0,
        S_EOP_J
    } state_t;

    state_t         state_q;
    logic [TW-1:0]  timer_q;
    logic [2:0]     bit_idx_q;   // bit of byte_q on the line (or next to send after a stuff bit)
    logic [7:0]     byte_q;
    logic           last_q;      // byte_q is the final payload byte
    logic           eop_next_q;  // the pending stuff bit is followed by EOP
    logic           abort_q;     // underrun seen: suppress tx_done
    logic           se0_cnt_q;
    logic [OW-1:0]  ones_q;
    logic           line_j_q;    // current NRZI level, 1 = J
    logic           dp_q;
    logic           dm_q;
    logic           busy_q;
    logic           ready_q;
    logic           done_q;

    logic           bit_end;
    logic           stuff_pend;
    logic           accept;
    logic           new_bit;     // an NRZI-coded bit starts on the line next cycle
    logic           new_val;
    logic           line_j_d;
    logic [OW-1:0]  ones_d;

    always_comb begin
        bit_end    = (timer_q == T_LAST);
        stuff_pend = (ones_q == O_MAX);
        accept     = ready_q && tx_valid;
        new_bit    = 1'b0;
        new_val    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (tx_start) begin
                    new_bit = 1'b1;
                    new_val = 1'b0;    // SYNC bit 0 of 8'h80
                end
            end
            S_SYNC, S_DATA: begin
                if (bit_end) begin
                    if (stuff_pend) begin
                        new_bit = 1'b1;
                        new_val = 1'b0;
                    end else if (bit_idx_q != 3'd7) begin
                        new_bit = 1'b1;
                        new_val = byte_q[bit_idx_q + 3'd1];
                    end else if (accept) begin
                        new_bit = 1'b1;
                        new_val = tx_data[0];
                    end
                end
            end
            S_STUFF: begin
                if (bit_end && !eop_next_q) begin
                    new_bit = 1'b1;
                    new_val = byte_q[bit_idx_q];
                end
            end
            default: begin
                new_bit = 1'b0;
                new_val = 1'b0;
            end
        endcase
        // NRZI: a 0 toggles the line, a 1 holds it; every 0 restarts the run of ones
        line_j_d = line_j_q;
        ones_d   = ones_q;
        if (new_bit) begin
            line_j_d = new_val ? line_j_q : ~line_j_q;
            ones_d   = new_val ? (ones_q + OW'(1)) : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            timer_q    <= '0;
            bit_idx_q  <= 3'd0;
            byte_q     <= 8'h00;
            last_q     <= 1'b0;
            eop_next_q <= 1'b0;
            abort_q    <= 1'b0;
            se0_cnt_q  <= 1'b0;
            ones_q     <= '0;
            line_j_q   <= 1'b1;
            dp_q       <= 1'b1;
            dm_q       <= 1'b0;
            busy_q     <= 1'b0;
            ready_q    <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            ready_q  <= 1'b0;
            done_q   <= 1'b0;
            line_j_q <= line_j_d;
            ones_q   <= ones_d;
            if (busy_q) begin
                timer_q <= bit_end ? '0 : (timer_q + TW'(1));
            end
            if (new_bit) begin
                dp_q <= line_j_d;
                dm_q <= ~line_j_d;
            end

            case (state_q)
                S_IDLE: begin
                    if (tx_start) begin
                        state_q    <= S_SYNC;
                        busy_q     <= 1'b1;
                        timer_q    <= '0;
                        bit_idx_q  <= 3'd0;
                        byte_q     <= 8'h80;
                        last_q     <= 1'b0;
                        eop_next_q <= 1'b0;
                        abort_q    <= 1'b0;
                    end
                end

                S_SYNC, S_DATA: begin
                    // Strobe ready in the final cycle of bit 7 unless this is the last byte
                    if (timer_q == T_PRE && bit_idx_q == 3'd7 &&
                        (state_q == S_SYNC || !last_q)) begin
                        ready_q <= 1'b1;
                    end
                    if (bit_end) begin
                        if (bit_idx_q != 3'd7) begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                            state_q   <= stuff_pend ? S_STUFF : S_DATA;
                        end else if (accept) begin
                            byte_q    <= tx_data;
                            last_q    <= tx_last;
                            bit_idx_q <= 3'd0;
                            state_q   <= stuff_pend ? S_STUFF : S_DATA;
                        end else begin
                            // Last byte sent or payload underrun: head for EOP
                            if (ready_q) begin
                                abort_q <= 1'b1;
                            end
                            if (stuff_pend) begin
                                eop_next_q <= 1'b1;
                                state_q    <= S_STUFF;
                            end else begin
                                state_q   <= S_EOP_SE0;
                                se0_cnt_q <= 1'b0;
                                dp_q      <= 1'b0;
                                dm_q      <= 1'b0;
                            end
                        end
                    end
                end

                S_STUFF: begin
                    if (bit_end) begin
                        if (eop_next_q) begin
                            state_q   <= S_EOP_SE0;
                            se0_cnt_q <= 1'b0;
                            dp_q      <= 1'b0;
                            dm_q      <= 1'b0;
                        end else begin
                            state_q <= S_DATA;
                        end
                    end
                end

                S_EOP_SE0: begin
                    if (bit_end) begin
                        if (se0_cnt_q) begin
                            state_q  <= S_EOP_J;
                            dp_q     <= 1'b1;
                            dm_q     <= 1'b0;
                            line_j_q <= 1'b1;
                        end else begin
                            se0_cnt_q <= 1'b1;
                        end
                    end
                end

                S_EOP_J: begin
                    if (timer_q == T_PRE) begin
                        done_q <= ~abort_q;
                    end
                    if (bit_end) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        timer_q <= '0;
                        ones_q  <= '0;
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign tx_ready    = ready_q;
    assign tx_error    = ready_q & ~tx_valid;
    assign d_plus_out  = dp_q;
    assign d_minus_out = dm_q;
    assign tx_busy     = busy_q;
    assign tx_done     = done_q;

endmodule
